// File: rtl/branch_resolve_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit_pkg
// Definitions shared between the BHT predictor and its resolve/update side:
// BHT index width, PC width, in-flight entry layout, resolve FSM encodings
// and the PC-to-BHT-index slice.
// ---------------------------------------------------------------------------
package branch_resolve_unit_pkg;

    localparam int unsigned LOWER   = 5;           // BHT index width
    localparam int unsigned PC_W    = 32;          // PC / target width
    localparam int unsigned ENTRY_W = 2*PC_W + 1;  // {pc, taken, target}

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } bru_state_t;

    // One in-flight prediction as recorded at fetch.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
    } bp_entry_t;

    // BHT index of a word-aligned PC; the predictor uses the same slice.
    function automatic logic [LOWER-1:0] bht_index(input logic [PC_W-1:0] pc);
        return pc[LOWER+1:2];
    endfunction

endpackage

// File: rtl/branch_resolve_unit_pred_queue.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit_pred_queue
// In-order FIFO of in-flight predictions.
//   clk, arst   : clock, async active-high reset
//   i_push      : write i_wdata (ignored when full or clearing)
//   i_pop       : drop the head entry (ignored when empty or clearing)
//   i_clear     : discard every entry, takes priority over push/pop
//   o_rdata_c   : head entry (combinational read)
//   o_count     : number of valid entries
//   o_full_c    : count == DEPTH
//   o_empty_c   : count == 0
// ---------------------------------------------------------------------------
module branch_resolve_unit_pred_queue #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_rdata_c,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full_c,
    output logic             o_empty_c
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~o_full_c  & ~i_clear;
    assign w_pop  = i_pop  & ~o_empty_c & ~i_clear;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata_c = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full_c  = (r_count == CNT_W'(DEPTH));
    assign o_empty_c = (r_count == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Resolve/update side of the 2-bit BHT. Queues predictions from fetch,
// compares each against the execute-stage outcome, writes the BHT and
// raises a one-cycle mispredict with the redirect PC.
//   clk, arst                       : clock, async active-high reset
//   pred_valid/pc/taken/target      : prediction issued at fetch
//   pred_ready                      : queue accepts a prediction
//   res_valid/taken/target          : resolution of the oldest branch
//   bht_en/write_addr/was_taken     : BHT update port (registered)
//   mispredict, redirect_pc         : flush pulse and restart PC (registered)
//   empty                           : no branches in flight
//   underflow_err                   : sticky, resolve seen with nothing queued
//   branch_cnt, mispred_cnt         : saturating statistics
// ---------------------------------------------------------------------------
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             pred_valid,
    input  logic [PC_W-1:0]  pred_pc,
    input  logic             pred_taken,
    input  logic [PC_W-1:0]  pred_target,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [PC_W-1:0]  res_target,
    output logic             bht_en,
    output logic [LOWER-1:0] bht_write_addr,
    output logic             bht_was_taken,
    output logic             mispredict,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             empty,
    output logic             underflow_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int unsigned QCNT_W = $clog2(DEPTH) + 1;

    bru_state_t        r_state;
    logic              r_bht_en;
    logic [LOWER-1:0]  r_bht_write_addr;
    logic              r_bht_was_taken;
    logic              r_mispredict;
    logic [PC_W-1:0]   r_redirect_pc;
    logic              r_underflow_err;
    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_mispred_cnt;

    bp_entry_t         w_wdata;
    bp_entry_t         w_head;
    logic [QCNT_W-1:0] w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_mispred;
    logic              w_underflow;

    assign w_wdata = '{pc: pred_pc, taken: pred_taken, target: pred_target};

    // No full-queue bypass: readiness depends on registered state only.
    assign w_ready = ~w_full & (r_state != FLUSH);
    assign w_push  = pred_valid & w_ready;
    assign w_pop   = res_valid & ~w_empty;

    // Direction mismatch, or both taken but to different targets.
    assign w_mispred = w_pop &
                       ((res_taken != w_head.taken) |
                        (res_taken & w_head.taken & (res_target != w_head.target)));

    // Queue is already empty during FLUSH, so only the state check is extra.
    assign w_underflow = res_valid & w_empty & (r_state != FLUSH);

    // A mispredict clears the wrong-path entries and drops a same-cycle push.
    branch_resolve_unit_pred_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_pred_queue (
        .clk       (clk),
        .arst      (arst),
        .i_push    (w_push),
        .i_wdata   (w_wdata),
        .i_pop     (w_pop),
        .i_clear   (w_mispred),
        .o_rdata_c (w_head),
        .o_count   (w_count),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    // Resolve FSM, registered BHT/redirect outputs and statistics.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state          <= IDLE;
            r_bht_en         <= 1'b0;
            r_bht_write_addr <= '0;
            r_bht_was_taken  <= 1'b0;
            r_mispredict     <= 1'b0;
            r_redirect_pc    <= '0;
            r_underflow_err  <= 1'b0;
            r_branch_cnt     <= '0;
            r_mispred_cnt    <= '0;
        end else begin
            case (r_state)
                FLUSH:   r_state <= IDLE;
                default: begin
                    if (w_mispred)
                        r_state <= FLUSH;
                    else if (w_push)
                        r_state <= ACTIVE;
                    else if (w_pop && (w_count == QCNT_W'(1)))
                        r_state <= IDLE;
                end
            endcase

            r_bht_en     <= w_pop;
            r_mispredict <= w_mispred;
            if (w_pop) begin
                r_bht_write_addr <= bht_index(w_head.pc);
                r_bht_was_taken  <= res_taken;
                r_redirect_pc    <= res_taken ? res_target : w_head.pc + PC_W'(4);
            end

            if (w_underflow) r_underflow_err <= 1'b1;

            if (w_pop && (r_branch_cnt != {CNT_W{1'b1}}))
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            if (w_mispred && (r_mispred_cnt != {CNT_W{1'b1}}))
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
        end
    end

    assign pred_ready     = w_ready;
    assign empty          = w_empty;
    assign bht_en         = r_bht_en;
    assign bht_write_addr = r_bht_write_addr;
    assign bht_was_taken  = r_bht_was_taken;
    assign mispredict     = r_mispredict;
    assign redirect_pc    = r_redirect_pc;
    assign underflow_err  = r_underflow_err;
    assign branch_cnt     = r_branch_cnt;
    assign mispred_cnt    = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed vectors for branch_resolve_unit. A second instance with 2-bit
// counters shares the stimulus to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic        clk;
    logic        arst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;

    logic        pred_ready;
    logic        bht_en;
    logic [4:0]  bht_write_addr;
    logic        bht_was_taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        empty;
    logic        underflow_err;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;

    logic        s_pred_ready;
    logic        s_bht_en;
    logic [4:0]  s_bht_write_addr;
    logic        s_bht_was_taken;
    logic        s_mispredict;
    logic [31:0] s_redirect_pc;
    logic        s_empty;
    logic        s_underflow_err;
    logic [1:0]  s_branch_cnt;
    logic [1:0]  s_mispred_cnt;

    int n_checks;
    int n_errors;
    int m_br;
    int m_mp;

    branch_resolve_unit #(.DEPTH(4), .CNT_W(16)) u_dut (
        .clk(clk), .arst(arst),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .bht_en(bht_en), .bht_write_addr(bht_write_addr), .bht_was_taken(bht_was_taken),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .empty(empty),
        .underflow_err(underflow_err), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_resolve_unit #(.DEPTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .arst(arst),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ready(s_pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .bht_en(s_bht_en), .bht_write_addr(s_bht_write_addr), .bht_was_taken(s_bht_was_taken),
        .mispredict(s_mispredict), .redirect_pc(s_redirect_pc), .empty(s_empty),
        .underflow_err(s_underflow_err), .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic        pt;
        logic [31:0] ptg;
        logic        rv;
        logic        rt;
        logic [31:0] rtg;
        logic        e_en;
        logic [4:0]  e_addr;
        logic        e_was;
        logic        e_mis;
        logic [31:0] e_redir;
        logic        e_empty;
        logic        e_ready;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(
        input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptg,
        input logic rv, input logic rt, input logic [31:0] rtg,
        input logic e_en, input logic [4:0] e_addr, input logic e_was,
        input logic e_mis, input logic [31:0] e_redir, input logic e_empty, input logic e_ready);
        vec_t v;
        v.pv = pv; v.ppc = ppc; v.pt = pt; v.ptg = ptg;
        v.rv = rv; v.rt = rt; v.rtg = rtg;
        v.e_en = e_en; v.e_addr = e_addr; v.e_was = e_was;
        v.e_mis = e_mis; v.e_redir = e_redir; v.e_empty = e_empty; v.e_ready = e_ready;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [31:0] ppc, input logic pt,
                         input logic [31:0] ptg, input logic rv, input logic rt,
                         input logic [31:0] rtg);
        pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
        res_valid = rv; res_taken = rt; res_target = rtg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(F, 32'h0, F, 32'h0, F, F, 32'h0);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, " branch_cnt"}, 32'(branch_cnt), 32'(m_br));
        chk({tag, " mispred_cnt"}, 32'(mispred_cnt), 32'(m_mp));
    endtask

    initial begin
        n_checks = 0; n_errors = 0; m_br = 0; m_mp = 0;
        clk = 1'b0;
        arst = 1'b1;
        idle();

        //            pv  ppc        pt  ptg        rv  rt  rtg         en  addr   was mis redir       empty rdy
        vecs[0]  = mk(T, 32'h40,  F, 32'h0,   F, F, 32'h0,   F, 5'h00, F, F, 32'h0,   F, T);
        vecs[1]  = mk(F, 32'h0,   F, 32'h0,   T, F, 32'h0,   T, 5'h10, F, F, 32'h0,   T, T);
        vecs[2]  = mk(T, 32'h30,  T, 32'h100, F, F, 32'h0,   F, 5'h00, F, F, 32'h0,   F, T);
        vecs[3]  = mk(F, 32'h0,   F, 32'h0,   T, T, 32'h104, T, 5'h0C, T, T, 32'h104, T, F);
        vecs[4]  = mk(T, 32'h50,  F, 32'h0,   T, F, 32'h0,   F, 5'h00, F, F, 32'h0,   T, T);
        vecs[5]  = mk(T, 32'h30,  T, 32'h100, F, F, 32'h0,   F, 5'h00, F, F, 32'h0,   F, T);
        vecs[6]  = mk(F, 32'h0,   F, 32'h0,   T, F, 32'h0,   T, 5'h0C, F, T, 32'h34,  T, F);
        vecs[7]  = mk(F, 32'h0,   F, 32'h0,   F, F, 32'h0,   F, 5'h00, F, F, 32'h0,   T, T);
        vecs[8]  = mk(T, 32'h60,  T, 32'h200, F, F, 32'h0,   F, 5'h00, F, F, 32'h0,   F, T);
        vecs[9]  = mk(F, 32'h0,   F, 32'h0,   T, T, 32'h200, T, 5'h18, T, F, 32'h0,   T, T);
        vecs[10] = mk(T, 32'h20,  F, 32'h0,   F, F, 32'h0,   F, 5'h00, F, F, 32'h0,   F, T);
        vecs[11] = mk(T, 32'h24,  F, 32'h0,   F, F, 32'h0,   F, 5'h00, F, F, 32'h0,   F, T);
        vecs[12] = mk(T, 32'h28,  F, 32'h0,   F, F, 32'h0,   F, 5'h00, F, F, 32'h0,   F, T);
        vecs[13] = mk(F, 32'h0,   F, 32'h0,   T, T, 32'h80,  T, 5'h08, T, T, 32'h80,  T, F);
        vecs[14] = mk(F, 32'h0,   F, 32'h0,   F, F, 32'h0,   F, 5'h00, F, F, 32'h0,   T, T);
        vecs[15] = mk(T, 32'h44,  F, 32'h0,   F, F, 32'h0,   F, 5'h00, F, F, 32'h0,   F, T);
        vecs[16] = mk(T, 32'h48,  T, 32'h300, T, F, 32'h0,   T, 5'h11, F, F, 32'h0,   F, T);
        vecs[17] = mk(F, 32'h0,   F, 32'h0,   T, T, 32'h300, T, 5'h12, T, F, 32'h0,   T, T);
        vecs[18] = mk(T, 32'h70,  F, 32'h0,   F, F, 32'h0,   F, 5'h00, F, F, 32'h0,   F, T);
        vecs[19] = mk(T, 32'h74,  F, 32'h0,   T, T, 32'h90,  T, 5'h1C, T, T, 32'h90,  T, F);
        vecs[20] = mk(F, 32'h0,   F, 32'h0,   F, F, 32'h0,   F, 5'h00, F, F, 32'h0,   T, T);

        // Reset state
        tick(); tick();
        @(negedge clk);
        arst = 1'b0;
        #1;
        chk("rst pred_ready", 32'(pred_ready), 32'd1);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst bht_en", 32'(bht_en), 32'd0);
        chk("rst mispredict", 32'(mispredict), 32'd0);
        chk("rst underflow", 32'(underflow_err), 32'd0);
        chk_cnt("rst");
        @(posedge clk);
        #1;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].pv, vecs[i].ppc, vecs[i].pt, vecs[i].ptg,
                  vecs[i].rv, vecs[i].rt, vecs[i].rtg);
            tick();
            if (vecs[i].e_en)  m_br++;
            if (vecs[i].e_mis) m_mp++;
            chk($sformatf("row%0d bht_en", i), 32'(bht_en), 32'(vecs[i].e_en));
            if (vecs[i].e_en) begin
                chk($sformatf("row%0d bht_write_addr", i), 32'(bht_write_addr), 32'(vecs[i].e_addr));
                chk($sformatf("row%0d bht_was_taken", i), 32'(bht_was_taken), 32'(vecs[i].e_was));
            end
            chk($sformatf("row%0d mispredict", i), 32'(mispredict), 32'(vecs[i].e_mis));
            if (vecs[i].e_mis)
                chk($sformatf("row%0d redirect_pc", i), redirect_pc, vecs[i].e_redir);
            chk($sformatf("row%0d empty", i), 32'(empty), 32'(vecs[i].e_empty));
            chk($sformatf("row%0d pred_ready", i), 32'(pred_ready), 32'(vecs[i].e_ready));
            chk($sformatf("row%0d underflow", i), 32'(underflow_err), 32'd0);
            chk_cnt($sformatf("row%0d", i));
        end
        idle();

        // Full queue: a fifth push with a simultaneous pop is refused
        for (int i = 0; i < 4; i++) begin
            drive(T, 32'h100 + 32'(4*i), F, 32'h0, F, F, 32'h0);
            tick();
        end
        idle();
        chk("full pred_ready", 32'(pred_ready), 32'd0);
        drive(T, 32'h1F0, F, 32'h0, T, F, 32'h0);
        tick();
        m_br++;
        chk("full pop bht_en", 32'(bht_en), 32'd1);
        chk("full pop addr", 32'(bht_write_addr), 32'd0);
        chk("full after pred_ready", 32'(pred_ready), 32'd1);
        chk("full after empty", 32'(empty), 32'd0);
        for (int i = 1; i < 4; i++) begin
            drive(F, 32'h0, F, 32'h0, T, F, 32'h0);
            tick();
            m_br++;
            chk($sformatf("drain%0d addr", i), 32'(bht_write_addr), 32'(i));
            chk($sformatf("drain%0d mispredict", i), 32'(mispredict), 32'd0);
        end
        idle();
        chk("drain empty", 32'(empty), 32'd1);
        chk_cnt("drain");

        // Resolve with nothing in flight
        drive(F, 32'h0, F, 32'h0, T, T, 32'h44);
        tick();
        idle();
        chk("underflow bht_en", 32'(bht_en), 32'd0);
        chk("underflow set", 32'(underflow_err), 32'd1);
        tick(); tick();
        chk("underflow sticky", 32'(underflow_err), 32'd1);
        chk_cnt("underflow");

        // 2-bit counters hold at their maximum
        chk("sat branch_cnt", 32'(s_branch_cnt), 32'd3);
        chk("sat mispred_cnt", 32'(s_mispred_cnt), 32'd3);

        // Asynchronous reset with three entries in flight
        for (int i = 0; i < 3; i++) begin
            drive(T, 32'h200 + 32'(4*i), T, 32'h400, F, F, 32'h0);
            tick();
        end
        idle();
        chk("pre-rst empty", 32'(empty), 32'd0);
        #2;
        arst = 1'b1;
        #1;
        m_br = 0; m_mp = 0;
        chk("midrst empty", 32'(empty), 32'd1);
        chk("midrst pred_ready", 32'(pred_ready), 32'd1);
        chk("midrst underflow", 32'(underflow_err), 32'd0);
        chk_cnt("midrst");
        @(negedge clk);
        arst = 1'b0;
        tick();
        chk("post-rst empty", 32'(empty), 32'd1);
        chk("post-rst bht_en", 32'(bht_en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Update/resolve side of the 2-bit branch history table.
- Tracks in-flight predictions made at fetch in an in-order queue.
- When execute resolves each branch, it compares the actual outcome with the prediction, drives the BHT write port (write_addr, was_taken, en), and raises a one-cycle mispredict with redirect PC.
- Sits between the fetch-stage predictor and the execute-stage branch comparator.

Parameters:
- LOWER, 5: BHT index width; index = pc[LOWER+1:2] (word-aligned PCs).
- PC_W, 32: PC and target width.
- DEPTH, 4: in-flight prediction queue entries; power of two, ≥2.
- CNT_W, 16: statistics counter width.

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- pred_valid  in  1  fetch issued a prediction for a branch this cycle.
- pred_pc  in  PC_W  PC of the predicted branch.
- pred_taken  in  1  predicted direction (BHT counter MSB).
- pred_target  in  PC_W  predicted target; don't-care if not taken.
- pred_ready  out  1  queue can accept a prediction.
- res_valid  in  1  execute resolved the oldest outstanding branch.
- res_taken  in  1  actual direction.
- res_target  in  PC_W  actual target.
- bht_en  out  1  BHT update strobe.
- bht_write_addr  out  LOWER  BHT index to update.
- bht_was_taken  out  1  actual direction for counter update.
- mispredict  out  1  one-cycle flush/redirect pulse.
- redirect_pc  out  PC_W  fetch restart PC; valid while mispredict=1.
- empty  out  1  no branches in flight.
- underflow_err  out  1  sticky: res_valid seen while queue empty.
- branch_cnt  out  CNT_W  resolved branches, saturating.
- mispred_cnt  out  CNT_W  mispredicts, saturating.

Behaviour:
- Reset (async, arst=1): queue emptied, FSM=IDLE, all outputs 0 except pred_ready=1 and empty=1. Counters=0. Reset mid-operation discards all in-flight entries immediately.
- Queue entry = {pc, taken, target}, in-order FIFO. Push on pred_valid & pred_ready. Pop on res_valid & !empty.
- pred_ready = (count<DEPTH) & (state!=FLUSH). No bypass: a push while full is refused even if a pop occurs in the same cycle.
- Push and pop in the same cycle: both happen, count unchanged.
- Mispredict condition on pop, head entry H: (res_taken != H.taken) | (res_taken & H.taken & res_target != H.target).
- Latency: all outputs are registered and assert one cycle after the res_valid edge.
  - bht_en=1 for exactly one cycle.
  - bht_write_addr = H.pc[LOWER+1:2].
  - bht_was_taken = res_taken.
  - mispredict=1 for one cycle on mispredict.
  - redirect_pc = res_taken ? res_target : H.pc+4 (mod 2^PC_W).
- Every resolution updates the BHT, correct or not.
- FSM states:
  - IDLE: count==0.
  - ACTIVE: count>0.
  - FLUSH: entered on a mispredict. Lasts exactly one cycle, then returns to IDLE.
- Mispredict handling: on the resolving edge, all younger entries are cleared (wrong path) and count=0. A push in that same cycle is dropped. In FLUSH, pred_ready=0 and res_valid is ignored and does not flag underflow.
- Transitions:
  - IDLE→ACTIVE on push.
  - ACTIVE→IDLE when the last entry pops without a push.
  - ACTIVE→FLUSH on mispredict.
- res_valid while empty (not FLUSH): no pop, no bht_en, underflow_err set until reset.
- Counters: branch_cnt +1 per pop, mispred_cnt +1 per mispredict. Both saturate at 2^CNT_W-1, never wrap.
- Queue pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.

Decomposition:
- Shared include/package bp_defs: LOWER, PC_W, entry-width localparam (2*PC_W+1), FSM state encodings (IDLE=2'd0, ACTIVE=2'd1, FLUSH=2'd2), and the index-slice macro shared with the BHT.
- One sub-module, pred_queue: parameterised FIFO with push, pop, clear, count, full, empty.
- FSM, compare logic, output registers and counters live in branch_resolve_unit.

Test Plan:
- Reset → pred_ready=1, empty=1, bht_en=0, mispredict=0, counters 0. Assert arst mid-stream with 3 entries → empty=1 immediately.
- Push pc=0x40 taken=0; resolve res_taken=0 → next cycle bht_en=1, bht_write_addr=0x10, bht_was_taken=0, mispredict=0, branch_cnt=1.
- Push 4 entries (DEPTH=4) → pred_ready=0. A 5th push with a simultaneous pop is refused. Next cycle pred_ready=1.
- Push pc=0x20 taken=0, then pc=0x24, pc=0x28; resolve first with res_taken=1, res_target=0x80 → mispredict=1, redirect_pc=0x80, empty=1, pred_ready=0 for one cycle, mispred_cnt=1.
- Push pc=0x30 taken=1 target=0x100; resolve res_taken=1 target=0x104 → mispredict=1, redirect_pc=0x104. Same with res_taken=0 → redirect_pc=0x34.
- res_valid on empty queue → no bht_en, underflow_err=1 and stays 1. Preload counters near max (CNT_W=2) → branch_cnt holds at 3.
